// File: rtl/fifo_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_pkg: shared packer state encoding and default sizing constants.
// Revision: 1.0
// ------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned PACK_DEFAULT       = 4;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ------------------------------------------------------------------
// stream_out_reg: single-entry valid/ready output holding register.
// Revision: 1.0
// ------------------------------------------------------------------
module stream_out_reg #(
  parameter int DW = 32,
  parameter int BW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [BW-1:0] load_bytes,
  input  logic          load_last,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic [BW-1:0] m_bytes,
  output logic          m_last,
  output logic          free
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [BW-1:0] bytes_q, bytes_d;
  logic          last_q, last_d;

  // The slot can take a new beat when empty or when the current one leaves now.
  assign free = !valid_q || m_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    bytes_d = bytes_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      bytes_d = load_bytes;
      last_d  = load_last;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      bytes_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      bytes_q <= bytes_d;
      last_q  <= last_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_bytes = bytes_q;
  assign m_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/fifo_byte_packer.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_byte_packer: packs FIFO words into wide beats, with partial flush.
// Revision: 1.0
// ------------------------------------------------------------------
module fifo_byte_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int PACK       = PACK_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_r_en,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [$clog2(PACK):0]      m_bytes,
  output logic                       m_last,
  output logic                       flush_busy
);

  localparam int LW     = $clog2(PACK);
  localparam int CW     = LW + 1;
  localparam int BEAT_W = DATA_WIDTH * PACK;
  localparam logic [CW-1:0] PACK_CNT = CW'(PACK);

  state_t            state_q, state_d;
  logic [CW-1:0]     lane_cnt_q, lane_cnt_d;
  logic              inflight_q, inflight_d;
  logic              run_en_q, run_en_d;
  logic [BEAT_W-1:0] acc_q, acc_d;

  logic [BEAT_W-1:0] acc_cap;
  logic [CW-1:0]     cnt_after;
  logic              out_free;
  logic              load;
  logic [BEAT_W-1:0] load_data;
  logic [CW-1:0]     load_bytes;
  logic              load_last;

  // Holds pops off until the first clock edge after reset release.
  assign run_en_d = 1'b1;

  assign fifo_r_en = run_en_q && !fifo_empty && (state_q == RUN) &&
                     ((lane_cnt_q + CW'(inflight_q)) < PACK_CNT);

  assign flush_busy = (state_q != RUN);

  always_comb begin
    acc_cap = acc_q;
    if (inflight_q) begin
      acc_cap[lane_cnt_q[LW-1:0]*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
    end
    cnt_after = lane_cnt_q + CW'(inflight_q);
  end

  // The accumulator is zeroed on every load, so lanes above the count are
  // already zero when a partial word is emitted.
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = cnt_after;
    acc_d      = acc_cap;
    inflight_d = fifo_r_en && !fifo_empty;
    load       = 1'b0;
    load_data  = acc_cap;
    load_bytes = PACK_CNT;
    load_last  = 1'b0;

    if (cnt_after == PACK_CNT) begin
      if (out_free) begin
        load       = 1'b1;
        lane_cnt_d = '0;
        acc_d      = '0;
      end
    end else if ((state_q == FLUSH_EMIT) && (lane_cnt_q != '0) && out_free) begin
      load       = 1'b1;
      load_bytes = lane_cnt_q;
      load_last  = 1'b1;
      lane_cnt_d = '0;
      acc_d      = '0;
    end

    case (state_q)
      RUN: begin
        if (flush) state_d = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (!inflight_q) state_d = FLUSH_EMIT;
      end
      FLUSH_EMIT: begin
        // A held full word drains as a normal beat first, then the
        // (now empty) remainder returns to RUN.
        if ((lane_cnt_q == '0) || ((lane_cnt_q != PACK_CNT) && out_free)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      lane_cnt_q <= '0;
      inflight_q <= 1'b0;
      run_en_q   <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      inflight_q <= inflight_d;
      run_en_q   <= run_en_d;
      acc_q      <= acc_d;
    end
  end

  stream_out_reg #(
    .DW(BEAT_W),
    .BW(CW)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_bytes(load_bytes),
    .load_last (load_last),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_bytes   (m_bytes),
    .m_last    (m_last),
    .free      (out_free)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fifo_byte_packer: directed bench for fifo_byte_packer (8-bit x 4).
// Revision: 1.0
// ------------------------------------------------------------------
module tb_fifo_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic [7:0]  fifo_data;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [2:0]  m_bytes;
  logic        m_last;
  logic        flush_busy;

  always #5 clk = ~clk;

  fifo_byte_packer #(
    .DATA_WIDTH(8),
    .PACK      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_r_en (fifo_r_en),
    .fifo_data (fifo_data),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_bytes   (m_bytes),
    .m_last    (m_last),
    .flush_busy(flush_busy)
  );

  // Upstream FIFO model with registered read data
  logic [7:0] src [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  // Accepted-beat log
  logic [31:0] bd [0:63];
  logic [2:0]  bb [0:63];
  logic        bl [0:63];
  int          beat_n = 0;
  logic        do_pop;

  always begin
    @(negedge clk);
    #2;
    do_pop = fifo_r_en && !fifo_empty;
    if (m_valid && m_ready && beat_n < 64) begin
      bd[beat_n] = m_data;
      bb[beat_n] = m_bytes;
      bl[beat_n] = m_last;
      beat_n++;
    end
    @(posedge clk);
    if (do_pop) begin
      fifo_data <= src[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] w);
    src[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rd_ptr != wr_ptr && n < 200) begin
      tick(1);
      n++;
    end
    chk("drain", 64'(rd_ptr), 64'(wr_ptr));
    tick(3);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  typedef struct {
    int          nw;
    logic [63:0] w;
    bit          fl;
    int          nb;
    logic [31:0] d0;
    logic [2:0]  b0;
    logic        l0;
    logic [31:0] d1;
    logic [2:0]  b1;
    logic        l1;
  } vec_t;

  vec_t vt [0:5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0n;
    int n;
    int p0;
    int cnt;
    int unstable;
    bit have;
    logic [31:0] first;
    logic [63:0] wv;

    vt[0] = '{4, 64'h44332211,         1'b0, 1, 32'h44332211, 3'd4, 1'b0, 32'h0,        3'd0, 1'b0};
    vt[1] = '{1, 64'h5A,               1'b1, 1, 32'h0000005A, 3'd1, 1'b1, 32'h0,        3'd0, 1'b0};
    vt[2] = '{3, 64'h030201,           1'b1, 1, 32'h00030201, 3'd3, 1'b1, 32'h0,        3'd0, 1'b0};
    vt[3] = '{0, 64'h0,                1'b1, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
    vt[4] = '{6, 64'hC6C5C4C3C2C1,     1'b1, 2, 32'hC4C3C2C1, 3'd4, 1'b0, 32'h0000C6C5, 3'd2, 1'b1};
    vt[5] = '{8, 64'hF7F6F5F4F3F2F1F0, 1'b0, 2, 32'hF3F2F1F0, 3'd4, 1'b0, 32'hF7F6F5F4, 3'd4, 1'b0};

    rst     = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;

    // Reset state
    tick(2);
    #1;
    chk("rst_r_en",  64'(fifo_r_en),  64'(0));
    chk("rst_valid", 64'(m_valid),    64'(0));
    chk("rst_data",  64'(m_data),     64'(0));
    chk("rst_bytes", 64'(m_bytes),    64'(0));
    chk("rst_last",  64'(m_last),     64'(0));
    chk("rst_busy",  64'(flush_busy), 64'(0));
    tick(1);
    rst = 1'b0;

    // Empty FIFO never popped
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      #1;
      if (fifo_r_en) cnt++;
    end
    chk("empty_r_en_cycles", 64'(cnt), 64'(0));

    // Table-driven vectors
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b0n = beat_n;
      wv  = vt[i].w;
      for (int k = 0; k < vt[i].nw; k++) push(wv[8*k +: 8]);
      drain();
      if (vt[i].fl) pulse_flush();
      tick(6);
      chk($sformatf("v%0d_nbeats", i), 64'(beat_n - b0n), 64'(vt[i].nb));
      if (vt[i].nb >= 1) begin
        chk($sformatf("v%0d_data0", i),  64'(bd[b0n]), 64'(vt[i].d0));
        chk($sformatf("v%0d_bytes0", i), 64'(bb[b0n]), 64'(vt[i].b0));
        chk($sformatf("v%0d_last0", i),  64'(bl[b0n]), 64'(vt[i].l0));
      end
      if (vt[i].nb >= 2) begin
        chk($sformatf("v%0d_data1", i),  64'(bd[b0n+1]), 64'(vt[i].d1));
        chk($sformatf("v%0d_bytes1", i), 64'(bb[b0n+1]), 64'(vt[i].b1));
        chk($sformatf("v%0d_last1", i),  64'(bl[b0n+1]), 64'(vt[i].l1));
      end
    end

    // Sustained throughput: 12 pops take 14 cycles (one bubble per beat)
    b0n = beat_n;
    for (int k = 0; k < 12; k++) push(8'(32'h20 + k));
    n = 0;
    while (rd_ptr != wr_ptr && n < 100) begin
      tick(1);
      n++;
    end
    chk("tput_cycles", 64'(n), 64'(14));
    tick(6);
    chk("tput_nbeats", 64'(beat_n - b0n), 64'(3));
    chk("tput_beat0", 64'(bd[b0n]),   64'(32'h23222120));
    chk("tput_beat1", 64'(bd[b0n+1]), 64'(32'h27262524));
    chk("tput_beat2", 64'(bd[b0n+2]), 64'(32'h2B2A2928));

    // Backpressure: 8 words with m_ready low for 20 cycles
    m_ready = 1'b0;
    b0n = beat_n;
    p0 = rd_ptr;
    for (int k = 1; k <= 8; k++) push(8'(k));
    unstable = 0;
    have = 1'b0;
    first = '0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      #1;
      if (m_valid) begin
        if (!have) begin
          first = m_data;
          have = 1'b1;
        end else if (m_data !== first || m_bytes !== 3'd4 || m_last !== 1'b0) begin
          unstable++;
        end
      end
    end
    chk("bp_first",    64'(first),       64'(32'h04030201));
    chk("bp_unstable", 64'(unstable),    64'(0));
    chk("bp_pops",     64'(rd_ptr - p0), 64'(8));
    chk("bp_r_en",     64'(fifo_r_en),   64'(0));
    chk("bp_valid",    64'(m_valid),     64'(1));
    m_ready = 1'b1;
    tick(6);
    chk("bp_nbeats", 64'(beat_n - b0n), 64'(2));
    chk("bp_beat0",  64'(bd[b0n]),      64'(32'h04030201));
    chk("bp_beat1",  64'(bd[b0n+1]),    64'(32'h08070605));

    // Partial flush of 0xAA,0xBB with flush_busy timing
    m_ready = 1'b0;
    b0n = beat_n;
    push(8'hAA);
    push(8'hBB);
    drain();
    pulse_flush();
    #1;
    chk("fl_busy_a",  64'(flush_busy), 64'(1));
    chk("fl_valid_a", 64'(m_valid),    64'(0));
    tick(1);
    #1;
    chk("fl_busy_b",  64'(flush_busy), 64'(1));
    chk("fl_valid_b", 64'(m_valid),    64'(0));
    tick(1);
    #1;
    chk("fl_busy_c",  64'(flush_busy), 64'(0));
    chk("fl_valid_c", 64'(m_valid),    64'(1));
    chk("fl_data",    64'(m_data),     64'(32'h0000BBAA));
    chk("fl_bytes",   64'(m_bytes),    64'(2));
    chk("fl_last",    64'(m_last),     64'(1));
    m_ready = 1'b1;
    tick(3);
    chk("fl_nbeats", 64'(beat_n - b0n), 64'(1));

    // Flush with empty accumulator, held 2 cycles (second cycle ignored)
    b0n = beat_n;
    cnt = 0;
    flush = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick(1);
      if (c == 1) flush = 1'b0;
      #1;
      if (flush_busy) cnt++;
    end
    chk("efl_busy_cycles", 64'(cnt),          64'(2));
    chk("efl_nbeats",      64'(beat_n - b0n), 64'(0));

    // Flush landing on the cycle the 4th lane is captured
    b0n = beat_n;
    for (int k = 0; k < 5; k++) push(8'(32'h31 + k));
    tick(4);
    pulse_flush();
    tick(6);
    chk("cof_nbeats", 64'(beat_n - b0n), 64'(1));
    chk("cof_data0",  64'(bd[b0n]),      64'(32'h34333231));
    chk("cof_bytes0", 64'(bb[b0n]),      64'(4));
    chk("cof_last0",  64'(bl[b0n]),      64'(0));
    drain();
    pulse_flush();
    tick(6);
    chk("cof_nbeats2", 64'(beat_n - b0n), 64'(2));
    chk("cof_data1",   64'(bd[b0n+1]),    64'(32'h00000035));
    chk("cof_bytes1",  64'(bb[b0n+1]),    64'(1));
    chk("cof_last1",   64'(bl[b0n+1]),    64'(1));

    // Asynchronous reset with a held beat and 3 lanes accumulated
    m_ready = 1'b0;
    b0n = beat_n;
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    push(8'h01); push(8'h02); push(8'h03);
    tick(14);
    chk("rs_pre_valid", 64'(m_valid), 64'(1));
    push(8'h05);
    rst = 1'b1;
    #1;
    chk("rs_valid", 64'(m_valid),    64'(0));
    chk("rs_data",  64'(m_data),     64'(0));
    chk("rs_bytes", 64'(m_bytes),    64'(0));
    chk("rs_last",  64'(m_last),     64'(0));
    chk("rs_r_en",  64'(fifo_r_en),  64'(0));
    chk("rs_busy",  64'(flush_busy), 64'(0));
    tick(2);
    rst = 1'b0;
    m_ready = 1'b1;
    push(8'h06); push(8'h07); push(8'h08);
    tick(14);
    chk("rs_nbeats", 64'(beat_n - b0n), 64'(1));
    chk("rs_data0",  64'(bd[b0n]),      64'(32'h08070605));
    chk("rs_bytes0", 64'(bb[b0n]),      64'(4));
    chk("rs_last0",  64'(bl[b0n]),      64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_byte_packer.md
FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the FIFO word width in bits.
REQ-002 Parameter PACK, default 4, SHALL set the FIFO words per output beat; PACK SHALL be a power of two, 2 or more.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 fifo_empty  in  1  upstream FIFO empty flag.
REQ-007 fifo_r_en  out  1  pop request to upstream FIFO.
REQ-008 fifo_data  in  DATA_WIDTH  FIFO registered read data, valid one cycle after an accepted pop.
REQ-009 flush  in  1  single-cycle request to emit any partial word.
REQ-010 m_valid  out  1  output beat valid.
REQ-011 m_ready  in  1  downstream accepts beat.
REQ-012 m_data  out  DATA_WIDTH*PACK  packed beat.
REQ-013 m_bytes  out  $clog2(PACK)+1  count of valid lanes in the beat, 1..PACK.
REQ-014 m_last  out  1  beat closes a flush.
REQ-015 flush_busy  out  1  flush accepted and not yet complete.

Function
REQ-016 A pop is accepted when fifo_r_en=1 and fifo_empty=0; the popped word SHALL be captured from fifo_data on the next rising edge.
REQ-017 fifo_r_en SHALL be 1 only when fifo_empty=0, state=RUN, and (lanes filled + pops in flight) < PACK.
REQ-018 Captured words SHALL fill lanes in order: the first word goes to m_data[DATA_WIDTH-1:0], lane k goes to bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-019 On capturing lane PACK-1, if the output register is empty or is being accepted that cycle, the full word SHALL load into the output register with m_bytes=PACK and m_last=0, and the lane count SHALL clear.
REQ-020 If the output register is occupied and not being accepted, the full accumulator SHALL hold with no further pops until the output register frees.
REQ-021 Sustained throughput with m_ready=1 and a non-empty FIFO SHALL be PACK pops every PACK+1 cycles; one bubble per beat is allowed.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_bytes and m_last SHALL hold stable.
REQ-023 The state machine SHALL have three states:
- RUN
- FLUSH_WAIT
- FLUSH_EMIT
REQ-024 RUN to FLUSH_WAIT: flush=1 in RUN; flush_busy SHALL rise the next cycle.
REQ-025 FLUSH_WAIT: no new pops; when no pop is in flight, go to FLUSH_EMIT.
REQ-026 FLUSH_EMIT with lane count 0: return to RUN with no beat emitted.
REQ-027 FLUSH_EMIT with lane count >0: when the output register frees, load the accumulator with m_bytes=lane count and m_last=1, zero the unused lanes, clear the accumulator, and return to RUN.
REQ-028 A flush arriving in the same cycle as a full-word completion SHALL treat that word as a normal beat (m_last=0) and flush only the remainder.
REQ-029 flush asserted while flush_busy=1 SHALL be ignored.
REQ-030 flush_busy SHALL be 1 exactly in FLUSH_WAIT and FLUSH_EMIT.

Reset
REQ-031 On rst=1, immediately and regardless of clk, the following SHALL clear to 0:
- fifo_r_en, m_valid, m_data, m_bytes, m_last, flush_busy
- lane count and in-flight counter
- state forced to RUN
REQ-032 Reset mid-operation SHALL discard accumulated lanes and any in-flight pop; data lost this way is not recovered.
REQ-033 After rst deasserts, the first pop SHALL be issued no earlier than the first rising edge.

Structure
REQ-034 A shared package fifo_pkg SHALL hold the state enum (RUN, FLUSH_WAIT, FLUSH_EMIT) and the PACK default constant.
REQ-035 The output holding register with its valid/ready hold logic SHALL be a sub-module, stream_out_reg.

Verification
REQ-036 Bench defaults are DATA_WIDTH=8 and PACK=4. The bench SHALL cover these directed scenarios:
- Push 0x11,0x22,0x33,0x44 with m_ready=1 -> one beat, m_data=0x44332211, m_bytes=4, m_last=0.
- Push 8 words 0x01..0x08 with m_ready=0 for 20 cycles -> first beat held stable; fifo_r_en=0 after 8 pops; on release, beats 0x04030201 then 0x08070605.
- Push 0xAA,0xBB then pulse flush -> beat m_data=0x0000BBAA, m_bytes=2, m_last=1; flush_busy high until the beat loads.
- Pulse flush with the accumulator empty -> no beat; flush_busy high for 2 cycles.
- Assert rst mid-word after 3 pops -> outputs 0 immediately; the next 4 pushes 0x5..0x8 yield 0x08070605.
- fifo_empty=1 continuously -> fifo_r_en never asserted.
